// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bundle: shared-memory request side plus decode-side valid/ready.
// FETCH_HALT_EN adds the fetch_halted status signal.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
) ();
  logic              instr_grant;
  logic [ADDR_W-1:0] mem_addr_instr;
  logic              mem_read_en_instr;
  logic [DATA_W-1:0] mem_read_val_instr;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [PC_W-1:0]   instr_pc;
`ifdef FETCH_HALT_EN
  logic              fetch_halted;
`endif

  modport master (
    input  instr_grant, mem_read_val_instr, redirect_valid, redirect_pc, instr_ready,
    output mem_addr_instr, mem_read_en_instr, instr_valid, instr_out, instr_pc
`ifdef FETCH_HALT_EN
    , output fetch_halted
`endif
  );

  modport slave (
    output instr_grant, mem_read_val_instr, redirect_valid, redirect_pc, instr_ready,
    input  mem_addr_instr, mem_read_en_instr, instr_valid, instr_out, instr_pc
`ifdef FETCH_HALT_EN
    , input fetch_halted
`endif
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, prefetch FIFO, redirect flush.
// FETCH_HALT_EN: an all-ones word stops fetching until the next redirect.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W     = 8,
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          PC_W       = 32,
  parameter int unsigned          FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0]      RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic              started_q;
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [PC_W-1:0]   pcs_q  [FIFO_DEPTH];

  logic req, push, pop, valid, full;

  assign full = (count_q == CntW'(FIFO_DEPTH));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = StRun;
`ifdef FETCH_HALT_EN
    end else if (push && (bus.mem_read_val_instr == {DATA_W{1'b1}})) begin
      state_d = StHalted;
`endif
    end
  end

  // FSM outputs; a redirect cycle blocks both request and head visibility
  always_comb begin
    req   = started_q & ~full & ~bus.redirect_valid & (state_q == StRun);
    valid = (count_q != '0) & ~bus.redirect_valid;
    push  = req & bus.instr_grant;
    pop   = valid & bus.instr_ready;
  end

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[PC_W-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + PC_W'(4);
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      started_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= bus.mem_read_val_instr;
      pcs_q[wr_ptr_q]  <= pc_q;
    end
  end

  assign bus.mem_addr_instr    = pc_q[ADDR_W+1:2];
  assign bus.mem_read_en_instr = req;
  assign bus.instr_valid       = valid;
  assign bus.instr_out         = data_q[rd_ptr_q];
  assign bus.instr_pc          = pcs_q[rd_ptr_q];
`ifdef FETCH_HALT_EN
  assign bus.fetch_halted      = (state_q == StHalted);
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: queue-level reference model predicts pushes,
// a separate monitor pops and compares each delivered instruction.
module tb_instr_fetch_unit;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam logic [PW-1:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW), .PC_W(PW)) bus ();

  instr_fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .PC_W(PW), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] memw [256];
  assign bus.mem_read_val_instr = bus.instr_grant ? memw[bus.mem_addr_instr] : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [DW-1:0] w;
  } ent_t;

  ent_t          exp_q[$];
  ent_t          mon_e;
  int            checks = 0;
  int            failures = 0;
  logic [PW-1:0] m_pc = RPC;
  bit            m_started = 1'b0;
  bit            m_halted = 1'b0;
  bit            m_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: runs after the stimulus checks, before the model applies this edge's push
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_empty actual=valid required=no_entry at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("head_pc", {32'h0, bus.instr_pc}, {32'h0, mon_e.pc});
          chk("head_word", {32'h0, bus.instr_out}, {32'h0, mon_e.w});
        end
      end
    end
  end

  task automatic step(input bit g, input bit r, input bit rv, input logic [PW-1:0] rpc);
    logic [DW-1:0] w;
    @(negedge clk);
    #1;
    rst_n              = 1'b1;
    bus.instr_grant    = g;
    bus.instr_ready    = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    m_req = m_started && (exp_q.size() < DEPTH) && !rv && !m_halted;
    chk("read_en", {63'h0, bus.mem_read_en_instr}, {63'h0, m_req});
    chk("addr", {56'h0, bus.mem_addr_instr}, {56'h0, m_pc[AW+1:2]});
    chk("valid", {63'h0, bus.instr_valid}, {63'h0, (exp_q.size() != 0) && !rv});
`ifdef FETCH_HALT_EN
    chk("halted", {63'h0, bus.fetch_halted}, {63'h0, m_halted});
`endif
    #2;
    if (rv) begin
      exp_q.delete();
      m_pc     = {rpc[PW-1:2], 2'b00};
      m_halted = 1'b0;
    end else if (m_req && g) begin
      w = memw[m_pc[AW+1:2]];
      exp_q.push_back({m_pc, w});
`ifdef FETCH_HALT_EN
      if (w == 32'hFFFF_FFFF) m_halted = 1'b1;
`endif
      m_pc = m_pc + 32'd4;
    end
    m_started = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memw[i] = 32'h1000_0000 + i;
`ifdef FETCH_HALT_EN
    memw[3] = 32'hFFFF_FFFF;
`endif
    bus.instr_grant    = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    #2;
    chk("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("rst_out", {32'h0, bus.instr_out}, 64'h0);
    chk("rst_pc", {32'h0, bus.instr_pc}, 64'h0);
    chk("rst_read_en", {63'h0, bus.mem_read_en_instr}, 64'h0);
    chk("rst_addr", {56'h0, bus.mem_addr_instr}, {56'h0, RPC[AW+1:2]});

    // Toggling grant, always-ready consumer
    for (int i = 0; i < 16; i++) step(i[0] == 1'b0, 1'b1, 1'b0, '0);

    // Stalled consumer fills the buffer, then one pop and a refill
    step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
    chk("full_valid", {63'h0, bus.instr_valid}, 64'h1);
    chk("full_read_en", {63'h0, bus.mem_read_en_instr}, 64'h0);
    chk("full_addr", {56'h0, bus.mem_addr_instr}, 64'h2);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("pop_no_req", {63'h0, bus.mem_read_en_instr}, 64'h0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("refill_req", {63'h0, bus.mem_read_en_instr}, 64'h1);
    chk("refill_addr", {56'h0, bus.mem_addr_instr}, 64'h2);

    // Redirect with a full buffer; low address bits dropped
    step(1'b0, 1'b0, 1'b1, 32'h0000_0107);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("redir_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("redir_addr", {56'h0, bus.mem_addr_instr}, 64'h41);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Word-address wrap-around
    step(1'b0, 1'b1, 1'b1, 32'h0000_03F8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Reset mid-operation with one entry held and grant active
    step(1'b0, 1'b0, 1'b1, 32'h0000_0010);
    step(1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    bus.instr_grant    = 1'b1;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    rst_n              = 1'b0;
    #1;
    chk("mid_rst_valid", {63'h0, bus.instr_valid}, 64'h0);
    chk("mid_rst_read_en", {63'h0, bus.mem_read_en_instr}, 64'h0);
    chk("mid_rst_addr", {56'h0, bus.mem_addr_instr}, {56'h0, RPC[AW+1:2]});
    exp_q.delete();
    m_pc      = RPC;
    m_started = 1'b0;
    m_halted  = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

`ifdef FETCH_HALT_EN
    step(1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk("halt_flag", {63'h0, bus.fetch_halted}, 64'h1);
    chk("halt_no_req", {63'h0, bus.mem_read_en_instr}, 64'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0020);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);
`endif

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
           32'($urandom_range(0, 32'h0000_0FFF)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
